// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, combinational imem address, and the IF/ID pipeline register.
// Optional static backward-taken/forward-not-taken branch prediction is enabled by FETCH_BTFN_PREDICT_EN.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        if_id_pred_taken
);

    localparam logic [31:0] BUBBLE_INST = 32'h0000_0013;

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_vld_q, if_vld_d;
    logic        if_pred_q, if_pred_d;

    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        pred_taken;

    assign seq_pc = pc_q + 32'd4;

`ifdef FETCH_BTFN_PREDICT_EN
    logic        is_bwd_branch;
    logic [31:0] b_imm;

    // A conditional branch with a negative offset is assumed to close a loop.
    assign is_bwd_branch = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
    assign b_imm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                    imem_rdata[11:8], 1'b0};
    assign pred_taken = is_bwd_branch;
    assign next_pc    = is_bwd_branch ? (pc_q + b_imm) : seq_pc;
`else
    assign pred_taken = 1'b0;
    assign next_pc    = seq_pc;
`endif

    always_comb begin
        pc_d      = pc_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        if_vld_d  = if_vld_q;
        if_pred_d = if_pred_q;
        if (redirect_valid) begin
            // Redirect wins over stall so a mispredict is never lost behind a hazard.
            pc_d      = {redirect_pc[31:2], 2'b00};
            if_inst_d = BUBBLE_INST;
            if_vld_d  = 1'b0;
            if_pred_d = 1'b0;
        end else if (flush) begin
            if_inst_d = BUBBLE_INST;
            if_vld_d  = 1'b0;
            if_pred_d = 1'b0;
            if (!stall) begin
                pc_d = next_pc;
            end
        end else if (!stall) begin
            if_pc_d   = pc_q;
            if_inst_d = imem_rdata;
            if_vld_d  = 1'b1;
            if_pred_d = pred_taken;
            pc_d      = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            if_pc_q   <= 32'h0000_0000;
            if_inst_q <= BUBBLE_INST;
            if_vld_q  <= 1'b0;
            if_pred_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
            if_vld_q  <= if_vld_d;
            if_pred_q <= if_pred_d;
        end
    end

    assign imem_addr        = pc_q;
    assign if_id_pc         = if_pc_q;
    assign if_id_inst       = if_inst_q;
    assign if_id_valid      = if_vld_q;
    assign if_id_pred_taken = if_pred_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: each driven cycle pushes the expected post-edge state,
// which is popped and compared one time unit after the rising edge.
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        if_id_pred_taken;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        vld;
        logic        pred;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_vld, m_pred;

    instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_id_pc        (if_id_pc),
        .if_id_inst      (if_id_inst),
        .if_id_valid     (if_id_valid),
        .if_id_pred_taken(if_id_pred_taken)
    );

    always #5 clk = ~clk;

    // Word i holds i, except a backward BEQ (offset -4) planted at 0x200.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'hFE00_0EE3;
        return {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic st, input logic fl,
                              input logic rv, input logic [31:0] rp);
        logic [31:0] w, tgt, off;
        logic        bt;
        w   = mem(m_pc);
        off = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
`ifdef FETCH_BTFN_PREDICT_EN
        bt  = (w[6:0] == 7'b1100011) && w[31];
`else
        bt  = 1'b0;
`endif
        tgt = bt ? m_pc + off : m_pc + 32'd4;
        if (!rn) begin
            m_pc = RST_PC; m_ifpc = 32'h0; m_inst = NOP; m_vld = 1'b0; m_pred = 1'b0;
        end else if (rv) begin
            m_pc = {rp[31:2], 2'b00}; m_inst = NOP; m_vld = 1'b0; m_pred = 1'b0;
        end else if (fl) begin
            m_inst = NOP; m_vld = 1'b0; m_pred = 1'b0;
            if (!st) m_pc = tgt;
        end else if (!st) begin
            m_ifpc = m_pc; m_inst = w; m_vld = 1'b1; m_pred = bt; m_pc = tgt;
        end
    endtask

    task automatic cycle(input logic rn, input logic st, input logic fl,
                         input logic rv, input logic [31:0] rp);
        exp_t e, o;
        @(negedge clk);
        rst_n = rn; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rp;
        model_step(rn, st, fl, rv, rp);
        e.addr = m_pc; e.pc = m_ifpc; e.inst = m_inst; e.vld = m_vld; e.pred = m_pred;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            chk("imem_addr", imem_addr, o.addr);
            chk("if_id_pc", if_id_pc, o.pc);
            chk("if_id_inst", if_id_inst, o.inst);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, o.vld});
            chk("if_id_pred", {31'd0, if_id_pred_taken}, {31'd0, o.pred});
        end
    endtask

    initial begin
        // Reset
        cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 1, 32'h4000);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_inst", if_id_inst, NOP);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_vld", {31'd0, if_id_valid}, 32'd0);

        // Sequential fetch after release
        cycle(1, 0, 0, 0, 32'h0);
        chk("seq_addr0", imem_addr, 32'h104);
        chk("seq_pc0", if_id_pc, 32'h100);
        chk("seq_inst0", if_id_inst, 32'h40);
        chk("seq_vld0", {31'd0, if_id_valid}, 32'd1);
        cycle(1, 0, 0, 0, 32'h0);
        chk("seq_addr1", imem_addr, 32'h108);

        // Three-cycle stall at 0x108, then resume
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 32'h0);
            chk("stall_addr", imem_addr, 32'h108);
            chk("stall_pc", if_id_pc, 32'h104);
        end
        cycle(1, 0, 0, 0, 32'h0);
        chk("resume_addr", imem_addr, 32'h10C);
        chk("resume_pc", if_id_pc, 32'h108);
        chk("resume_inst", if_id_inst, 32'h42);

        // Redirect beats stall, low bits dropped
        cycle(1, 1, 0, 1, 32'h0000_2003);
        chk("redir_addr", imem_addr, 32'h2000);
        chk("redir_inst", if_id_inst, NOP);
        chk("redir_vld", {31'd0, if_id_valid}, 32'd0);
        chk("redir_pc", if_id_pc, 32'h108);
        cycle(1, 0, 0, 0, 32'h0);

        // PC wraps modulo 2^32
        cycle(1, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);

        // Backward branch at 0x200
        cycle(1, 0, 0, 1, 32'h200);
        cycle(1, 0, 0, 0, 32'h0);
`ifdef FETCH_BTFN_PREDICT_EN
        chk("br_addr", imem_addr, 32'h1FC);
        chk("br_pred", {31'd0, if_id_pred_taken}, 32'd1);
`else
        chk("br_addr", imem_addr, 32'h204);
        chk("br_pred", {31'd0, if_id_pred_taken}, 32'd0);
`endif

        // Flush together with stall at 0x300, then flush alone
        cycle(1, 0, 0, 1, 32'h2FC);
        cycle(1, 0, 0, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);
        chk("flst_addr", imem_addr, 32'h300);
        chk("flst_vld", {31'd0, if_id_valid}, 32'd0);
        chk("flst_inst", if_id_inst, NOP);
        chk("flst_pc", if_id_pc, 32'h2FC);
        cycle(1, 0, 1, 0, 32'h0);
        chk("fl_addr", imem_addr, 32'h304);

        // Random mix of controls
        for (int i = 0; i < 60; i++) begin
            logic st, fl, rv;
            logic [31:0] rp;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 5) == 0);
            rv = ($urandom_range(0, 7) == 0);
            rp = ($urandom_range(0, 3) == 0) ? 32'h200 : ($urandom & 32'h0000_FFFF);
            cycle(1, st, fl, rv, rp);
        end

        // Reset mid-operation discards redirect and stall
        cycle(0, 1, 1, 1, 32'h8000);
        chk("mrst_addr", imem_addr, RST_PC);
        chk("mrst_vld", {31'd0, if_id_valid}, 32'd0);
        cycle(1, 0, 0, 0, 32'h0);
        chk("mrst_first_pc", if_id_pc, RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port: stall  input  1  hold PC and IF/ID register.
REQ-006 Port: flush  input  1  replace IF/ID contents with a bubble.
REQ-007 Port: redirect_valid  input  1  EX-stage control transfer taken or mispredicted.
REQ-008 Port: redirect_pc  input  32  corrected fetch address.
REQ-009 Port: imem_addr  output  32  instruction memory address (combinational-read memory).
REQ-010 Port: imem_rdata  input  32  instruction word at imem_addr, same cycle.
REQ-011 Port: if_id_pc  output  32  PC of the registered instruction.
REQ-012 Port: if_id_inst  output  32  registered instruction; drives the decoder and the immediate generator's inst_code.
REQ-013 Port: if_id_valid  output  1  registered instruction is real (not a bubble).
REQ-014 Port: if_id_pred_taken  output  1  fetch predicted this branch taken.

Function
REQ-015 imem_addr SHALL equal the PC register combinationally; no address latency.
REQ-016 Bubble encoding SHALL be if_id_inst=32'h0000_0013 (ADDI x0,x0,0), if_id_valid=0, if_id_pred_taken=0, if_id_pc unchanged.
REQ-017 Update priority SHALL be: rst_n low > redirect_valid > flush > stall > prediction > sequential.
REQ-018 redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble; applies even when stall=1.
REQ-019 flush=1, no redirect: IF/ID <= bubble; PC advances per REQ-021/REQ-022 unless stall=1, then PC held.
REQ-020 stall=1, no redirect/flush: PC and all IF/ID outputs SHALL hold their values.
REQ-021 Otherwise: IF/ID <= {pc, imem_rdata, valid=1, pred}; PC <= next PC.
REQ-022 Sequential next PC = PC + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Fetch-to-IF/ID latency SHALL be one cycle; throughput one instruction per unstalled cycle.
REQ-024 First valid instruction SHALL appear in IF/ID one cycle after the first edge with rst_n high, carrying if_id_pc=RESET_PC.

Reset
REQ-025 On an edge with rst_n=0: PC=RESET_PC, if_id_pc=0, if_id_inst=32'h0000_0013, if_id_valid=0, if_id_pred_taken=0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight instruction, stall or redirect that cycle.

Configuration
REQ-027 Macro FETCH_BTFN_PREDICT_EN SHALL enable static backward-taken/forward-not-taken prediction.
REQ-028 With macro: if imem_rdata[6:0]=7'b1100011 and imem_rdata[31]=1, next PC = PC + sign-extended B-immediate {inst[31],inst[7],inst[30:25],inst[11:8],0}, mod 2^32; pred bit = 1.
REQ-029 With macro: forward branches and all other opcodes use PC+4, pred bit = 0; prediction suppressed by redirect, flush-only path still predicts.
REQ-030 Without macro: next PC always PC+4; if_id_pred_taken tied 0; no adder for branch target.

Verification
REQ-031 Reset, RESET_PC=32'h100, memory word[i]=i: release rst_n -> imem_addr 0x100,0x104,0x108; IF/ID pc trails by one cycle, valid=1.
REQ-032 stall held 3 cycles at PC=0x108 -> imem_addr and IF/ID frozen 3 cycles, resume at 0x10C with no skipped or duplicated instruction.
REQ-033 redirect_valid=1, redirect_pc=32'h0000_2003, with stall=1 -> next imem_addr=0x2000, IF/ID bubble (inst 0x00000013, valid 0).
REQ-034 PC=32'hFFFF_FFFC, no stall -> next imem_addr=0x0000_0000.
REQ-035 With FETCH_BTFN_PREDICT_EN, PC=0x200, inst=32'hFE000EE3 (BEQ offset -4) -> next imem_addr=0x1FC, if_id_pred_taken=1; without macro -> 0x204, pred 0.
REQ-036 flush=1 and stall=1 together at PC=0x300 -> IF/ID bubble, PC held at 0x300.
